// File: rtl/alu_logop_seq_if.sv
// rtl/alu_logop_seq_if.sv - Operand/result handshake bus for alu_logop_seq.
// LogOp_zero exists only when LOGOP_ZERO_FLAG_EN is defined.
interface alu_logop_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALU_dat1;
  logic [WIDTH-1:0] ALU_dat2;
  logic [4:0]       Instruction_to_ALU;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] LogOp_out;
  logic             LogOp_err;
`ifdef LOGOP_ZERO_FLAG_EN
  logic             LogOp_zero;
`endif

  modport master (
`ifdef LOGOP_ZERO_FLAG_EN
    input  LogOp_zero,
`endif
    output in_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, out_ready,
    input  in_ready, out_valid, LogOp_out, LogOp_err
  );

  modport slave (
`ifdef LOGOP_ZERO_FLAG_EN
    output LogOp_zero,
`endif
    input  in_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, out_ready,
    output in_ready, out_valid, LogOp_out, LogOp_err
  );
endinterface

// File: rtl/alu_logop_seq.sv
// rtl/alu_logop_seq.sv - Handshaked AND/OR/XOR and iterative SLL/SRL/SRA unit.
// Define LOGOP_ZERO_FLAG_EN to add the registered LogOp_zero result flag.
module alu_logop_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic           soc_clk,
  input  logic           reset,
  alu_logop_seq_if.slave bus
);
  localparam int          SW   = $clog2(WIDTH);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  localparam logic [4:0] OP_AND = 5'd15;
  localparam logic [4:0] OP_OR  = 5'd14;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_SLL = 5'd12;
  localparam logic [4:0] OP_SRL = 5'd13;
  localparam logic [4:0] OP_SRA = 5'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shop_e;

  state_e           state_q;
  shop_e            shop_q, shop_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]    rem_q;
  logic             err_q, err_d;

  logic             accept, is_logic, is_shift, out_load;
  logic [WIDTH-1:0] logic_res;
  logic [SW-1:0]    shamt, step_k;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.LogOp_out = out_q;
  assign bus.LogOp_err = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign shamt  = bus.ALU_dat2[SW-1:0];
  // Last step of a shift may be shorter than SHIFT_STEP.
  assign step_k = ({1'b0, rem_q} >= STEP) ? STEP[SW-1:0] : rem_q;

  always_comb begin
    is_logic  = 1'b1;
    is_shift  = 1'b0;
    logic_res = '0;
    shop_d    = SH_LL;
    case (bus.Instruction_to_ALU)
      OP_AND:  logic_res = bus.ALU_dat1 & bus.ALU_dat2;
      OP_OR:   logic_res = bus.ALU_dat1 | bus.ALU_dat2;
      OP_XOR:  logic_res = bus.ALU_dat1 ^ bus.ALU_dat2;
      OP_SLL:  begin is_logic = 1'b0; is_shift = 1'b1; shop_d = SH_LL; end
      OP_SRL:  begin is_logic = 1'b0; is_shift = 1'b1; shop_d = SH_RL; end
      OP_SRA:  begin is_logic = 1'b0; is_shift = 1'b1; shop_d = SH_RA; end
      default: is_logic = 1'b0;
    endcase
  end

  always_comb begin
    work_d = work_q;
    case (shop_q)
      SH_LL:   work_d = work_q << step_k;
      SH_RL:   work_d = work_q >> step_k;
      default: work_d = WIDTH'($signed(work_q) >>> step_k);
    endcase
  end

  always_comb begin
    out_load = 1'b0;
    out_d    = out_q;
    err_d    = err_q;
    if (state_q == SHIFT) begin
      if (rem_q == step_k) begin
        out_load = 1'b1;
        out_d    = work_d;
        err_d    = 1'b0;
      end
    end else if (accept) begin
      if (is_logic) begin
        out_load = 1'b1;
        out_d    = logic_res;
        err_d    = 1'b0;
      end else if (!is_shift) begin
        out_load = 1'b1;
        out_d    = '0;
        err_d    = 1'b1;
      end else if (shamt == '0) begin
        out_load = 1'b1;
        out_d    = bus.ALU_dat1;
        err_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shop_q  <= SH_LL;
      work_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (out_load) begin
        out_q <= out_d;
        err_q <= err_d;
      end
      case (state_q)
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_q - step_k;
          if (rem_q == step_k) state_q <= DONE;
        end
        default: begin
          if (accept) begin
            if (is_shift) begin
              work_q <= bus.ALU_dat1;
              rem_q  <= shamt;
              shop_q <= shop_d;
            end
            state_q <= (is_shift && (shamt != '0)) ? SHIFT : DONE;
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef LOGOP_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset)        zero_q <= 1'b0;
    else if (out_load) zero_q <= (out_d == '0) && !err_d;
  end

  assign bus.LogOp_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_logop_seq.sv
// tb/tb_alu_logop_seq.sv - Scoreboard testbench for alu_logop_seq (WIDTH 32, SHIFT_STEP 4).
// Runs the LogOp_zero scenario when LOGOP_ZERO_FLAG_EN is defined.
module tb_alu_logop_seq;
  localparam logic [4:0] OP_AND = 5'd15;
  localparam logic [4:0] OP_OR  = 5'd14;
  localparam logic [4:0] OP_XOR = 5'd11;
  localparam logic [4:0] OP_SLL = 5'd12;
  localparam logic [4:0] OP_SRL = 5'd13;
  localparam logic [4:0] OP_SRA = 5'd10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_logop_seq_if #(.WIDTH(32)) bus ();
  alu_logop_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut (.soc_clk(clk), .reset(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q [$];
  logic [32:0] exp;

  logic [4:0]  sh_op  [7] = '{OP_SRA, OP_SRL, OP_SRL, OP_SLL, OP_SRA, OP_SLL, OP_SRA};
  logic [31:0] sh_a   [7] = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'h0000_ABCD,
                              32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
  logic [31:0] sh_b   [7] = '{32'd9, 32'd9, 32'h23, 32'hFFFF_FFE0, 32'd31, 32'd31, 32'd4};
  logic [31:0] sh_exp [7] = '{32'hFFC0_0000, 32'h0040_0000, 32'h1000_0002, 32'h0000_ABCD,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'h07FF_FFFF};
  int          sh_lat [7] = '{4, 4, 2, 1, 9, 9, 2};
  logic [4:0]  rnd_ops [8] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, 5'd0, 5'd31};

  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      OP_AND:  model = {1'b0, a & b};
      OP_OR:   model = {1'b0, a | b};
      OP_XOR:  model = {1'b0, a ^ b};
      OP_SLL:  model = {1'b0, a << s};
      OP_SRL:  model = {1'b0, a >> s};
      OP_SRA:  model = {1'b0, 32'($signed(a) >>> s)};
      default: model = {1'b1, 32'h0};
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.Instruction_to_ALU = op;
    bus.ALU_dat1 = a;
    bus.ALU_dat2 = b;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.LogOp_out !== 32'h0) begin fails++; $display("FAIL reset_out got %h want 0", bus.LogOp_out); end
    tests++; if (bus.LogOp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.LogOp_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_logic_b2b();
    logic [4:0]  ops  [3] = '{OP_AND, OP_OR, OP_XOR};
    logic [31:0] exps [3] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(ops[i], 32'hF0F0_1234, 32'h0FF0_FF00);
      else bus.in_valid = 1'b0;
      #1;
      if (i > 0) begin
        pop_exp();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got %b want 1", i-1, bus.out_valid); end
        tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL b2b_out[%0d] got %h want %h", i-1, bus.LogOp_out, exp[31:0]); end
        tests++; if (bus.LogOp_err !== exp[32]) begin fails++; $display("FAIL b2b_err[%0d] got %b want %b", i-1, bus.LogOp_err, exp[32]); end
      end
      if (i < 3) begin
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
        exp_q.push_back({1'b0, exps[i]});
      end
      @(negedge clk);
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b want 0", bus.out_valid); end
  endtask

  task automatic test_shift();
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(sh_op[i], sh_a[i], sh_b[i]);
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL shift_accept[%0d] got %b want 1", i, bus.in_ready); end
      exp_q.push_back({1'b0, sh_exp[i]});
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      if (sh_lat[i] > 1) begin
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL shift_busy[%0d] in_ready got %b want 0", i, bus.in_ready); end
      end
      while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
      pop_exp();
      tests++; if (lat != sh_lat[i]) begin fails++; $display("FAIL shift_latency[%0d] got %0d want %0d", i, lat, sh_lat[i]); end
      tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL shift_out[%0d] got %h want %h", i, bus.LogOp_out, exp[31:0]); end
      tests++; if (bus.LogOp_err !== 1'b0) begin fails++; $display("FAIL shift_err[%0d] got %b want 0", i, bus.LogOp_err); end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid();
    bus.out_ready = 1'b1;
    drive(5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    drive(OP_AND, 32'hFFFF_FFFF, 32'h0000_FFFF);
    #1;
    pop_exp();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL inv_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL inv_out got %h want %h", bus.LogOp_out, exp[31:0]); end
    tests++; if (bus.LogOp_err !== exp[32]) begin fails++; $display("FAIL inv_err got %b want %b", bus.LogOp_err, exp[32]); end
    exp_q.push_back({1'b0, 32'h0000_FFFF});
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop_exp();
    tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL inv_next_out got %h want %h", bus.LogOp_out, exp[31:0]); end
    tests++; if (bus.LogOp_err !== exp[32]) begin fails++; $display("FAIL inv_next_err got %b want %b", bus.LogOp_err, exp[32]); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(OP_XOR, 32'h1234_5678, 32'hFFFF_0000);
    exp_q.push_back({1'b0, 32'hEDCB_5678});
    @(negedge clk);
    drive(OP_AND, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      tests++; if (bus.LogOp_out !== exp_q[0][31:0]) begin fails++; $display("FAIL bp_hold[%0d] got %h want %h", i, bus.LogOp_out, exp_q[0][31:0]); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    pop_exp();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL bp_release_out got %h want %h", bus.LogOp_out, exp[31:0]); end
    exp_q.push_back({1'b0, 32'h0505_0505});
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop_exp();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL bp_next_out got %h want %h", bus.LogOp_out, exp[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.out_ready = 1'b1;
    drive(OP_SLL, 32'h0000_0001, 32'd20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.LogOp_out !== 32'h0) begin fails++; $display("FAIL rmid_out got %h want 0", bus.LogOp_out); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rmid_stale got %0d results want 0", seen); end
  endtask

`ifdef LOGOP_ZERO_FLAG_EN
  task automatic test_zero_flag();
    bus.out_ready = 1'b1;
    drive(OP_XOR, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    drive(5'd5, 32'h0, 32'h0);
    #1;
    tests++; if (bus.LogOp_out !== 32'h0) begin fails++; $display("FAIL zf_xor_out got %h want 0", bus.LogOp_out); end
    tests++; if (bus.LogOp_zero !== 1'b1) begin fails++; $display("FAIL zf_xor_zero got %b want 1", bus.LogOp_zero); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if (bus.LogOp_err !== 1'b1) begin fails++; $display("FAIL zf_inv_err got %b want 1", bus.LogOp_err); end
    tests++; if (bus.LogOp_zero !== 1'b0) begin fails++; $display("FAIL zf_inv_zero got %b want 0", bus.LogOp_zero); end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    logic pending = 1'b0;
    logic [4:0] op;
    logic [31:0] a, b;
    while ((sent < 24 || exp_q.size() > 0) && cyc < 3000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 24 && !pending) begin
        op = rnd_ops[$urandom_range(0, 7)];
        a = $urandom;
        b = $urandom;
        pending = 1'b1;
      end
      if (pending) drive(op, a, b);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        pop_exp();
        tests++; if (bus.LogOp_out !== exp[31:0]) begin fails++; $display("FAIL rnd_out got %h want %h", bus.LogOp_out, exp[31:0]); end
        tests++; if (bus.LogOp_err !== exp[32]) begin fails++; $display("FAIL rnd_err got %b want %b", bus.LogOp_err, exp[32]); end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(op, a, b));
        sent++;
        pending = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests++; if (sent != 24 || exp_q.size() != 0) begin fails++; $display("FAIL rnd_drain sent %0d pending %0d want 24 and 0", sent, exp_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Instruction_to_ALU = 5'd0;
    bus.ALU_dat1 = 32'h0;
    bus.ALU_dat2 = 32'h0;
    test_reset();
    test_logic_b2b();
    test_shift();
    test_invalid();
    test_backpressure();
    test_reset_mid();
`ifdef LOGOP_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/alu_logop_seq.md
# alu_logop_seq

Parametrised, handshaked successor of the ALU logical-operation unit. Performs true bitwise AND/OR/XOR and iterative shifts (SLL/SRL/SRA) on WIDTH-bit operands, with a valid/ready interface so the ALU can stall it. Results and an invalid-opcode error flag are registered. Sits in the ALU beside the arithmetic units, fed by the ALU operand/instruction bus.

## Interface
- WIDTH, 32, operand/result width in bits; power of two, ≥ 8.
- SHIFT_STEP, 1, bit positions shifted per cycle in the SHIFT state; power of two, 1..WIDTH.
- soc_clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  unit can accept an operation this cycle.
- ALU_dat1  in  WIDTH  operand A; shift source for shifts.
- ALU_dat2  in  WIDTH  operand B; low log2(WIDTH) bits are the shift amount for shifts.
- Instruction_to_ALU  in  5  opcode: 15 AND, 14 OR, 11 XOR, 12 SLL, 13 SRL, 10 SRA; any other value is invalid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- LogOp_out  out  WIDTH  result.
- LogOp_err  out  1  high with out_valid when the accepted opcode was invalid.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
- On accept of AND/OR/XOR: LogOp_out ← bitwise A op B over all WIDTH bits; LogOp_err ← 0; → DONE.
- On accept of invalid opcode: LogOp_out ← 0; LogOp_err ← 1; → DONE.
- On accept of shift: shamt = ALU_dat2[log2(WIDTH)-1:0], upper bits ignored; work register ← A; remaining ← shamt; if shamt==0 → DONE with LogOp_out=A, else → SHIFT.
- SHIFT: each cycle shift by k = min(SHIFT_STEP, remaining); SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates original bit WIDTH-1. remaining -= k; when remaining becomes 0, load LogOp_out and → DONE.
- DONE: out_valid=1; LogOp_out/LogOp_err stable until out_ready. On out_ready: if a new accept occurs in the same cycle, process it (logic/invalid/zero-shift → stay DONE with new result; shift → SHIFT, out_valid low next cycle); else → IDLE.
- Inputs are sampled only on accept; changes at other times have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1 (combinational from IDLE), LogOp_out 0, LogOp_err 0, work register 0.
- Logic, invalid, or zero shift: out_valid one cycle after accept. Throughput one op per cycle while out_ready=1.
- Shift of n>0: out_valid 1 + ceil(n/SHIFT_STEP) cycles after accept. in_ready low throughout SHIFT.
- Back-pressure: out_ready=0 in DONE holds the result indefinitely; in_ready stays low.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; in-flight operation discarded, no result produced.
- Max shift WIDTH-1: SRA of 0x80000000 by 31 (WIDTH 32) = 0xFFFFFFFF.

## Configuration
- LOGOP_ZERO_FLAG_EN defined: adds output LogOp_zero (1 bit), registered with LogOp_out, high when result is all-zero and LogOp_err=0; reset value 0.
- Not defined: no LogOp_zero port and no zero-detect logic; all other behaviour identical.

## Test plan
- Reset mid-operation: accept SLL 0x1 by 20 (SHIFT_STEP=1), assert reset after 5 cycles -> out_valid 0, LogOp_out 0, in_ready 1 immediately; after release, no stale result appears.
- Logic ops back-to-back with out_ready=1: AND/OR/XOR of 0xF0F0_1234, 0x0FF0_FF00 on consecutive cycles -> 0x00F0_1200, 0xFFF0_FF34, 0xFF00_ED34 on three consecutive cycles, LogOp_err 0.
- Shift latency: SHIFT_STEP=4, SRA 0x8000_0010 by 9 -> result 0xFFC0_0000 exactly 4 cycles after accept; SRL same -> 0x0040_0000; shamt field 0x23 (bit 5 set) treated as 3.
- Invalid opcode 5 with operands 0xFFFF_FFFF -> LogOp_out 0, LogOp_err 1 one cycle later; next valid op clears LogOp_err.
- Back-pressure: out_ready=0 for 10 cycles in DONE with in_valid=1 -> result stable, in_ready 0, no accept; raising out_ready accepts the pending op in the same cycle.
- LOGOP_ZERO_FLAG_EN build: XOR 0x1234_5678 with itself -> LogOp_out 0, LogOp_zero 1; invalid opcode -> LogOp_zero 0.
